mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win.
REQ-002 Parameter: TIMEOUT, 64, cycles a memory transaction may wait for M_RDY before abort.
REQ-003 One clock; reset is asynchronous and active-low: CLK, RST_N.
REQ-004 CLK  in  1  clock; all state changes on posedge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 IF_REQ  in  1  fetch request; held with IF_ADDR until IF_GNT.
REQ-007 IF_ADDR  in  16  fetch byte address.
REQ-008 IF_GNT  out  1  one-cycle pulse: fetch request accepted.
REQ-009 IF_VALID  out  1  one-cycle pulse: IF_RDATA valid.
REQ-010 IF_RDATA  out  32  fetched instruction word.
REQ-011 D_REQ  in  1  data request; held with D_* until D_GNT.
REQ-012 D_WE  in  1  1 = store, 0 = load.
REQ-013 D_ADDR  in  16  data byte address.
REQ-014 D_WDATA  in  32  store data.
REQ-015 D_SIZE  in  2  access size (funct3[1:0] encoding).
REQ-016 D_GNT / D_VALID  out  1 each  as IF_GNT / IF_VALID, data port; D_VALID also pulses for stores.
REQ-017 D_RDATA  out  32  load data.
REQ-018 M_REQ, M_WE  out  1 each  memory request / write enable.
REQ-019 M_ADDR  out  16; M_WDATA  out  32; M_SIZE  out  2  latched transaction fields.
REQ-020 M_RDY  in  1; M_RDATA  in  32  memory completion and read data.
REQ-021 STALL_IF, STALL_ME  out  1 each  requester REQ high and its VALID low this cycle.
REQ-022 ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-023 FSM states IDLE, BUSY_IF, BUSY_D; IDLE on reset.
REQ-024 IDLE with any REQ: choose winner, latch its fields into M_*, pulse its GNT and assert M_REQ in the next cycle, enter BUSY_x.
REQ-025 Priority: data wins over fetch unless starvation count == STARVE_MAX, then fetch wins.
REQ-026 Starvation count increments on each data grant with IF_REQ high, clears on fetch grant or IF_REQ low, saturates at STARVE_MAX.
REQ-027 BUSY_x: M_* held stable; on M_RDY, capture M_RDATA into x_RDATA (loads/fetch only), pulse x_VALID next cycle, M_REQ deasserted next cycle, return to IDLE.
REQ-028 Minimum latency: REQ in IDLE at t, GNT and M_REQ at t+1, M_RDY at t+1 gives VALID at t+2; next grant no earlier than t+3.
REQ-029 Wait counter runs in BUSY_x; reaching TIMEOUT without M_RDY: drop M_REQ, pulse ERR, pulse x_VALID with x_RDATA = 32'h0000_0013 (NOP) for fetch, 0 for data, return to IDLE.
REQ-030 M_RDY in IDLE ignored; REQ deassertion during BUSY does not cancel the transaction.
REQ-031 x_RDATA holds last value until next capture.

Reset
REQ-032 RST_N low: state IDLE, counters 0, all outputs 0, including mid-transaction (transaction dropped, no VALID).
REQ-033 First grant possible in the first posedge after RST_N deasserts.

Structure
REQ-034 State enum, source constants (SRC_IF = 0, SRC_D = 1) and NOP constant in shared package bb_mem_pkg.
REQ-035 One sub-module, wait_timer: loadable counter with terminal flag, used for TIMEOUT.

Verification
REQ-036 IF_REQ only, IF_ADDR=16'h0010, M_RDY 2 cycles after M_REQ, M_RDATA=32'h00500093 -> IF_GNT at t+1, IF_VALID at t+4, IF_RDATA=32'h00500093.
REQ-037 IF_REQ and D_REQ (load, 16'h0100) same cycle -> D_GNT first; IF_GNT after D_VALID; STALL_IF high throughout wait.
REQ-038 D_REQ and IF_REQ continuously high, zero-wait memory -> exactly 4 data grants then 1 fetch grant, repeating.
REQ-039 Store D_WDATA=32'hDEADBEEF, D_SIZE=2 -> M_WE=1, M_WDATA=32'hDEADBEEF held until M_RDY; D_VALID pulses once.
REQ-040 M_RDY never asserted on fetch -> ERR and IF_VALID at cycle 64 after M_REQ, IF_RDATA=32'h00000013, FSM IDLE.
REQ-041 RST_N pulled low mid BUSY_D -> outputs 0 immediately, no D_VALID, next request served normally.

Source files
------------

// File: rtl/bb_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Contents:
//   arb_state_e  arbiter FSM states
//   SRC_IF/SRC_D requester identifiers
//   NOP_INSN     instruction returned to fetch when a transaction is aborted
//   SIZE_WORD    access size used for instruction fetches
//   fetch_wins   arbitration rule shared by the arbiter
package bb_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyD  = 2'd2
    } arb_state_e;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_D  = 1'b1;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    // Data normally wins; fetch wins when it is alone or has been starved too long.
    function automatic logic fetch_wins(input logic if_req, input logic d_req,
                                        input logic starved);
        return if_req && (!d_req || starved);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter with a terminal flag, used to bound memory waits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val (has priority over en)
//   load_val    value loaded into the counter
//   en          decrement by one (stops at zero)
//   term        counter is zero
module wait_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             term
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign term = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, data) arbiter in front of a single-ported memory.
// One transaction is outstanding at a time. Data has priority unless fetch has
// been passed over STARVE_MAX consecutive times. A transaction that sees no
// m_rdy within TIMEOUT cycles is aborted with an err pulse.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (held until if_gnt)
//   if_gnt/if_valid/if_rdata        fetch grant pulse, completion pulse, read data
//   d_req/d_we/d_addr/d_wdata/d_size data request (held until d_gnt)
//   d_gnt/d_valid/d_rdata           data grant pulse, completion pulse, load data
//   m_req/m_we/m_addr/m_wdata/m_size memory request with latched fields
//   m_rdy/m_rdata                   memory completion and read data
//   stall_if/stall_me               requester waiting (req high, valid low)
//   err                             pulse on timeout abort
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic        m_rdy,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_me,
    output logic        err
);

    import bb_mem_pkg::*;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_e  state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [1:0]  m_size_q, m_size_d;
    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;

    logic tmr_load, tmr_en, tmr_term;
    logic win_src;

    // Loaded with TIMEOUT-1 at grant; reaching zero means the last allowed busy cycle.
    wait_timer #(
        .WIDTH (TW)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TW'(TIMEOUT - 1)),
        .en       (tmr_en),
        .term     (tmr_term)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_size_d   = m_size_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = 1'b0;
        starve_d   = starve_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        win_src    = SRC_D;

        // Starvation only accumulates while fetch keeps asking.
        if (!if_req) begin
            starve_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    win_src  = fetch_wins(if_req, d_req, starve_q == SW'(STARVE_MAX)) ?
                               SRC_IF : SRC_D;
                    m_req_d  = 1'b1;
                    tmr_load = 1'b1;
                    if (win_src == SRC_IF) begin
                        state_d   = StBusyIf;
                        if_gnt_d  = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                        m_size_d  = SIZE_WORD;
                        starve_d  = '0;
                    end else begin
                        state_d   = StBusyD;
                        d_gnt_d   = 1'b1;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_size_d  = d_size;
                        if (if_req && (starve_q != SW'(STARVE_MAX))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            StBusyIf, StBusyD: begin
                if (m_rdy) begin
                    state_d = StIdle;
                    m_req_d = 1'b0;
                    if (state_q == StBusyIf) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end else if (tmr_term) begin
                    state_d = StIdle;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = NOP_INSN;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_size_q   <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_size_q   <= m_size_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
        end
    end

    assign if_gnt   = if_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_size   = m_size_q;
    assign err      = err_q;

    // Gated by reset so every output reads zero while rst_n is low.
    assign stall_if = rst_n & if_req & ~if_valid_q;
    assign stall_me = rst_n & d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// The model schedules each granted transaction by cycle numbers (grant, ready,
// completion) and keeps the starvation rule as a plain integer.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_valid;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [15:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        m_req, m_we, m_rdy;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic        stall_if, stall_me, err;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_size   (d_size),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_size   (m_size),
        .m_rdy    (m_rdy),
        .m_rdata  (m_rdata),
        .stall_if (stall_if),
        .stall_me (stall_me),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Requester-side stimulus state.
    bit          if_pend, d_pend;
    logic [15:0] if_addr_v, d_addr_v;
    logic        d_we_v;
    logic [31:0] d_wdata_v;
    logic [1:0]  d_size_v;
    int          if_gnt_cyc, d_gnt_cyc;
    int          p_if, p_d;
    int          lat_mode, fixed_lat;
    bit          fixed_data_en;
    logic [31:0] fixed_data;

    // Reference model.
    bit          mb_busy, mb_src_d, mb_to;
    int          t_gnt, t_rdy, t_done;
    logic        mb_we;
    logic [15:0] mb_addr;
    logic [31:0] mb_wdata, rdy_data;
    logic [1:0]  mb_size;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    int          starve;
    bit          ev_if_valid, ev_d_valid, ev_err;

    // Observation recorders for directed sections.
    bit rec_gnt[$];
    int dv_cnt, err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_if_gnt"}, if_gnt, 0);
        check({pfx, "_if_valid"}, if_valid, 0);
        check({pfx, "_if_rdata"}, if_rdata, 0);
        check({pfx, "_d_gnt"}, d_gnt, 0);
        check({pfx, "_d_valid"}, d_valid, 0);
        check({pfx, "_d_rdata"}, d_rdata, 0);
        check({pfx, "_m_req"}, m_req, 0);
        check({pfx, "_m_we"}, m_we, 0);
        check({pfx, "_m_addr"}, m_addr, 0);
        check({pfx, "_m_wdata"}, m_wdata, 0);
        check({pfx, "_m_size"}, m_size, 0);
        check({pfx, "_stall_if"}, stall_if, 0);
        check({pfx, "_stall_me"}, stall_me, 0);
        check({pfx, "_err"}, err, 0);
    endtask

    task automatic model_reset();
        mb_busy = 0; starve = 0;
        exp_if_rdata = '0; exp_d_rdata = '0;
        ev_if_valid = 0; ev_d_valid = 0; ev_err = 0;
        if_pend = 0; d_pend = 0;
        if_gnt_cyc = -10; d_gnt_cyc = -10;
    endtask

    task automatic post_if(input logic [15:0] a);
        if_pend = 1; if_addr_v = a;
    endtask

    task automatic post_d(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input logic [1:0] sz);
        d_pend = 1; d_we_v = we; d_addr_v = a; d_wdata_v = wd; d_size_v = sz;
    endtask

    function automatic int pick_latency();
        int r;
        if (lat_mode == 1) return fixed_lat;
        r = int'($urandom_range(99));
        if (r < 3) return TIMEOUT;          // never ready: abort
        if (r < 6) return TIMEOUT - 1;      // ready on the last allowed cycle
        return int'($urandom_range(3));
    endfunction

    // One clock cycle: drive inputs, decide in the model, advance, check registers.
    task automatic step();
        int lat;
        bit fetch;
        if (if_pend && cyc == if_gnt_cyc + 1) if_pend = 0;
        if (d_pend && cyc == d_gnt_cyc + 1) d_pend = 0;
        if (!if_pend && int'($urandom_range(99)) < p_if) post_if(16'($urandom));
        if (!d_pend && int'($urandom_range(99)) < p_d)
            post_d(1'($urandom), 16'($urandom), $urandom, 2'($urandom));

        m_rdy   = 1'b0;
        m_rdata = $urandom;
        if (mb_busy) begin
            if (cyc == t_rdy) begin
                m_rdy = 1'b1;
                if (fixed_data_en) m_rdata = fixed_data;
                rdy_data = m_rdata;
            end
        end else if ($urandom_range(3) == 0) begin
            m_rdy = 1'b1;  // stray ready while idle must be ignored
        end
        if_req = if_pend; if_addr = if_addr_v;
        d_req = d_pend; d_we = d_we_v; d_addr = d_addr_v; d_wdata = d_wdata_v; d_size = d_size_v;
        #1;
        check("stall_if", stall_if, if_pend && !ev_if_valid);
        check("stall_me", stall_me, d_pend && !ev_d_valid);

        if (!mb_busy && (if_pend || d_pend)) begin
            fetch    = if_pend && (!d_pend || starve == STARVE_MAX);
            mb_src_d = !fetch;
            t_gnt    = cyc + 1;
            if (fetch) begin
                if_gnt_cyc = t_gnt;
                mb_we = 1'b0; mb_addr = if_addr_v;
                starve = 0;
            end else begin
                d_gnt_cyc = t_gnt;
                mb_we = d_we_v; mb_addr = d_addr_v; mb_wdata = d_wdata_v; mb_size = d_size_v;
                starve = if_pend ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
            end
            lat = pick_latency();
            if (lat >= TIMEOUT) begin
                mb_to = 1; t_rdy = -1; t_done = t_gnt + TIMEOUT;
            end else begin
                mb_to = 0; t_rdy = t_gnt + lat; t_done = t_rdy + 1;
            end
            mb_busy = 1;
        end else if (!if_pend) begin
            starve = 0;
        end

        @(posedge clk);
        cyc++;
        #1;
        ev_if_valid = 0; ev_d_valid = 0; ev_err = 0;
        if (mb_busy && cyc == t_done) begin
            if (mb_to) begin
                ev_err = 1;
                if (mb_src_d) exp_d_rdata = '0; else exp_if_rdata = NOP;
            end else if (!mb_src_d) begin
                exp_if_rdata = rdy_data;
            end else if (!mb_we) begin
                exp_d_rdata = rdy_data;
            end
            ev_if_valid = !mb_src_d;
            ev_d_valid  = mb_src_d;
            mb_busy = 0;
        end

        check("if_gnt", if_gnt, mb_busy && cyc == t_gnt && !mb_src_d);
        check("d_gnt", d_gnt, mb_busy && cyc == t_gnt && mb_src_d);
        check("if_valid", if_valid, ev_if_valid);
        check("d_valid", d_valid, ev_d_valid);
        check("err", err, ev_err);
        check("m_req", m_req, mb_busy);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        if (mb_busy) begin
            check("m_addr", m_addr, mb_addr);
            check("m_we", m_we, mb_we);
            if (mb_src_d) begin
                check("m_wdata", m_wdata, mb_wdata);
                check("m_size", m_size, mb_size);
            end
        end

        if (d_gnt === 1'b1) rec_gnt.push_back(1'b1);
        if (if_gnt === 1'b1) rec_gnt.push_back(1'b0);
        if (d_valid === 1'b1) dv_cnt++;
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_rec();
        rec_gnt.delete();
        dv_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_size = '0;
        m_rdy = 0; m_rdata = '0;
        if_addr_v = '0; d_addr_v = '0; d_we_v = 0; d_wdata_v = '0; d_size_v = '0;
        mb_we = 0; mb_addr = '0; mb_wdata = '0; mb_size = '0; rdy_data = '0;
        mb_src_d = 0; mb_to = 0; t_gnt = -10; t_rdy = -10; t_done = -10;
        p_if = 0; p_d = 0; lat_mode = 1; fixed_lat = 0; fixed_data_en = 0; fixed_data = '0;
        model_reset();
        clear_rec();

        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch, memory ready two cycles after m_req.
        post_if(16'h0010);
        lat_mode = 1; fixed_lat = 2; fixed_data_en = 1; fixed_data = 32'h0050_0093;
        run(8);
        check("fetch_rdata", if_rdata, 32'h0050_0093);

        // Fetch and load arrive together: data first.
        clear_rec();
        fixed_data_en = 0; fixed_lat = 3;
        post_if(16'h0040);
        post_d(1'b0, 16'h0100, 32'h0, 2'b10);
        run(14);
        check("both_ngrants", rec_gnt.size(), 2);
        if (rec_gnt.size() >= 2) begin
            check("both_first_is_d", rec_gnt[0], 1'b1);
            check("both_second_is_if", rec_gnt[1], 1'b0);
        end

        // Store with a four-cycle memory wait.
        clear_rec();
        fixed_lat = 4;
        post_d(1'b1, 16'h0200, 32'hDEAD_BEEF, 2'b10);
        run(10);
        check("store_dvalid_cnt", dv_cnt, 1);

        // Fetch never acknowledged: abort after TIMEOUT cycles.
        clear_rec();
        fixed_lat = TIMEOUT;
        post_if(16'h0020);
        run(TIMEOUT + 6);
        check("timeout_err_cnt", err_cnt, 1);
        check("timeout_rdata", if_rdata, NOP);

        // Both requesters always asking, zero-wait memory.
        clear_rec();
        fixed_lat = 0; p_if = 100; p_d = 100;
        run(60);
        check("starve_ngrants_ge15", rec_gnt.size() >= 15, 1'b1);
        for (int i = 0; i < 15 && i < rec_gnt.size(); i++)
            check($sformatf("starve_pattern_%0d", i), rec_gnt[i], (i % 5) != 4);
        p_if = 0; p_d = 0;
        run(8);

        // Random traffic with random latency, including timeouts and the boundary.
        p_if = 35; p_d = 35; lat_mode = 0;
        run(3000);
        p_if = 0; p_d = 0;
        run(TIMEOUT + 4);

        // Reset in the middle of a data transaction.
        lat_mode = 1; fixed_lat = TIMEOUT;
        post_d(1'b0, 16'h0300, 32'h0, 2'b10);
        run(4);
        #2;
        if_req = 1'b1;
        d_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        if_req = 0; d_req = 0; m_rdy = 0;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rst_n = 1'b1;
        clear_rec();
        fixed_lat = 1; fixed_data_en = 1; fixed_data = 32'h1234_5678;
        post_d(1'b0, 16'h0400, 32'h0, 2'b10);
        run(8);
        check("postrst_dvalid_cnt", dv_cnt, 1);
        check("postrst_rdata", d_rdata, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
